// File: rtl/serial_subtract_ctrl.sv
// serial_subtract_ctrl: bit-serial a - b over WIDTH bits, LSB first.
// One bit is processed per clock through a shared 1-bit subtract slice.
// The slice is two cascaded half-subtractors plus a borrow register.
//
// Optional macro SERSUB_OVF_EN adds the output ovf.
// ovf is the signed two's-complement overflow of the final result.
// When the macro is undefined, the port and its logic are absent.
module serial_subtract_ctrl #(
    parameter int WIDTH = 8,
    localparam int CNT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
`ifdef SERSUB_OVF_EN
    output logic             ovf,
`endif
    output logic             outborrow
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    state_t             state;
    logic [WIDTH-1:0]   a_reg;
    logic [WIDTH-1:0]   b_reg;
    logic [CNT_W-1:0]   cnt;
    logic               borrow;

    // Slice signals for the bit currently selected by cnt
    logic a_bit;
    logic b_bit;
    logic hs1_d;
    logic hs1_b;
    logic hs2_d;
    logic hs2_b;
    logic bout;

    // Shared 1-bit subtract slice: (a_bit - b_bit), then subtract the incoming borrow
    always_comb begin
        a_bit = a_reg[cnt];
        b_bit = b_reg[cnt];
        hs1_d = a_bit ^ b_bit;
        hs1_b = ~a_bit & b_bit;
        hs2_d = hs1_d ^ borrow;
        hs2_b = ~hs1_d & borrow;
        bout  = hs1_b | hs2_b;
    end

    // Control FSM with registered outputs; diff is built up one bit per RUN cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            a_reg     <= '0;
            b_reg     <= '0;
            cnt       <= '0;
            borrow    <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            diff      <= '0;
            outborrow <= 1'b0;
`ifdef SERSUB_OVF_EN
            ovf       <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        // Operands are captured only here; later input changes are ignored
                        a_reg  <= a;
                        b_reg  <= b;
                        diff   <= '0;
                        borrow <= 1'b0;
                        cnt    <= '0;
                        busy   <= 1'b1;
                        state  <= RUN;
                    end
                end
                RUN: begin
                    diff[cnt] <= hs2_d;
                    borrow    <= bout;
                    cnt       <= cnt + CNT_W'(1);
                    if (cnt == LAST_BIT) begin
                        // MSB edge: publish the final borrow and hand off to DONE
                        outborrow <= bout;
`ifdef SERSUB_OVF_EN
                        ovf       <= (a_bit ^ b_bit) & (a_bit ^ hs2_d);
`endif
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    // Single-cycle done pulse; start is not looked at here
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_subtract_ctrl.sv
// Testbench for serial_subtract_ctrl (WIDTH=8): table-driven operations plus
// hand-written sequences for ignored start, mid-run reset and held start.
module tb_serial_subtract_ctrl;

    localparam int WIDTH = 8;

    logic             clk;
    logic             rst;
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             outborrow;
`ifdef SERSUB_OVF_EN
    logic             ovf;
`endif

    int checks = 0;
    int errors = 0;

    serial_subtract_ctrl #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .a         (a),
        .b         (b),
        .busy      (busy),
        .done      (done),
        .diff      (diff),
`ifdef SERSUB_OVF_EN
        .ovf       (ovf),
`endif
        .outborrow (outborrow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] va;
        logic [7:0] vb;
        logic [7:0] exp_diff;
        logic       exp_borrow;
        logic       exp_ovf;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Full operation starting from IDLE, called with time just after a posedge.
    task automatic do_op(input vec_t v);
        logic [7:0] mask;
        start = 1'b1;
        a     = v.va;
        b     = v.vb;
        @(posedge clk); #1;              // edge k: accepted
        start = 1'b0;
        a     = ~v.va;                   // must not affect the running operation
        b     = ~v.vb;
        check("busy_after_accept", {31'b0, busy}, 32'd1);
        check("diff_cleared", {24'b0, diff}, 32'd0);
        for (int c = 1; c < WIDTH; c++) begin
            @(posedge clk); #1;
            mask = 8'((1 << c) - 1);
            check("busy_run", {31'b0, busy}, 32'd1);
            check("done_run", {31'b0, done}, 32'd0);
            check("diff_partial", {24'b0, diff}, {24'b0, v.exp_diff & mask});
        end
        @(posedge clk); #1;              // edge k+WIDTH
        check("done_pulse", {31'b0, done}, 32'd1);
        check("busy_fall", {31'b0, busy}, 32'd0);
        check("diff", {24'b0, diff}, {24'b0, v.exp_diff});
        check("outborrow", {31'b0, outborrow}, {31'b0, v.exp_borrow});
`ifdef SERSUB_OVF_EN
        check("ovf", {31'b0, ovf}, {31'b0, v.exp_ovf});
`endif
        @(posedge clk); #1;              // edge k+WIDTH+1: back to IDLE
        check("done_single", {31'b0, done}, 32'd0);
        check("diff_hold", {24'b0, diff}, {24'b0, v.exp_diff});
        check("outborrow_hold", {31'b0, outborrow}, {31'b0, v.exp_borrow});
        $display("op a=%02h b=%02h -> diff=%02h outborrow=%0d", v.va, v.vb, diff, outborrow);
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int done_cnt;
        vecs[0] = '{8'h05, 8'h03, 8'h02, 1'b0, 1'b0};
        vecs[1] = '{8'h03, 8'h05, 8'hFE, 1'b1, 1'b0};
        vecs[2] = '{8'h00, 8'h00, 8'h00, 1'b0, 1'b0};
        vecs[3] = '{8'hFF, 8'hFF, 8'h00, 1'b0, 1'b0};
        vecs[4] = '{8'h80, 8'h01, 8'h7F, 1'b0, 1'b1};
        vecs[5] = '{8'h7F, 8'hFF, 8'h80, 1'b1, 1'b1};
        vecs[6] = '{8'hAA, 8'h55, 8'h55, 1'b0, 1'b1};
        vecs[7] = '{8'h55, 8'hAA, 8'hAB, 1'b1, 1'b1};

        rst   = 1'b1;
        start = 1'b0;
        a     = '0;
        b     = '0;
        #12;
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_done", {31'b0, done}, 32'd0);
        check("rst_diff", {24'b0, diff}, 32'd0);
        check("rst_outborrow", {31'b0, outborrow}, 32'd0);
`ifdef SERSUB_OVF_EN
        check("rst_ovf", {31'b0, ovf}, 32'd0);
`endif
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;

        // Table-driven operations
        for (int i = 0; i < 8; i++) begin
            do_op(vecs[i]);
        end

        // Start pulsed during RUN is ignored
        start = 1'b1; a = 8'h10; b = 8'h01;
        @(posedge clk); #1;
        start = 1'b0;
        done_cnt = 0;
        for (int c = 1; c <= WIDTH + 4; c++) begin
            @(posedge clk); #1;
            if (done) done_cnt++;
            if (c == 2) begin start = 1'b1; a = 8'hAA; b = 8'h55; end
            if (c == 3) start = 1'b0;
            if (c == WIDTH) begin
                check("ign_done", {31'b0, done}, 32'd1);
                check("ign_diff", {24'b0, diff}, 32'h0F);
                check("ign_outborrow", {31'b0, outborrow}, 32'd0);
            end
            if (c > WIDTH) check("ign_no_restart", {31'b0, busy}, 32'd0);
        end
        check("ign_single_done", done_cnt, 32'd1);
        $display("op a=10 b=01 with ignored start -> diff=%02h done_pulses=%0d", diff, done_cnt);

        // Reset asserted in the 4th RUN cycle
        start = 1'b1; a = 8'h80; b = 8'h01;
        @(posedge clk); #1;
        start = 1'b0;
        for (int c = 1; c <= 3; c++) begin
            @(posedge clk); #1;
        end
        check("pre_rst_diff", {24'b0, diff}, 32'h07);
        rst = 1'b1;
        #1;
        check("midrst_busy", {31'b0, busy}, 32'd0);
        check("midrst_done", {31'b0, done}, 32'd0);
        check("midrst_diff", {24'b0, diff}, 32'd0);
        check("midrst_outborrow", {31'b0, outborrow}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        done_cnt = 0;
        for (int c = 0; c < WIDTH + 4; c++) begin
            @(posedge clk); #1;
            if (done || busy) done_cnt++;
        end
        check("midrst_no_activity", done_cnt, 32'd0);
        $display("op a=80 b=01 reset mid-run -> diff=%02h", diff);
        do_op(vecs[4]);

        // Start held high: a new operation every WIDTH+2 cycles
        start = 1'b1; a = 8'h05; b = 8'h03;
        @(posedge clk); #1;
        for (int c = 1; c <= WIDTH + 2; c++) begin
            @(posedge clk); #1;
            if (c == WIDTH)     check("held_done1", {31'b0, done}, 32'd1);
            if (c == WIDTH + 1) check("held_idle_busy", {31'b0, busy}, 32'd0);
            if (c == WIDTH + 2) begin
                check("held_restart_busy", {31'b0, busy}, 32'd1);
                check("held_restart_diff", {24'b0, diff}, 32'd0);
            end
        end
        start = 1'b0;
        done_cnt = 0;
        for (int c = 1; c <= WIDTH + 2; c++) begin
            @(posedge clk); #1;
            if (done) begin
                done_cnt++;
                check("held_diff2", {24'b0, diff}, 32'h02);
            end
        end
        check("held_done2", done_cnt, 32'd1);
        $display("op a=05 b=03 start held -> diff=%02h", diff);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
